iter_mult_ctrl: RTL
===================

Name: iter_mult_ctrl

Overview:
- Multi-cycle controller that sequences the existing combinational vedic_8x8 multiplier to compute wide unsigned products, e.g. 16-bit range × 16-bit probability terms in the encoder datapath.
- Splits each operand into 8-bit chunks and issues one chunk pair to a single vedic_8x8 instance per cycle.
- Shift-accumulates the partial products into the result.
- Uses valid/ready handshakes on both the input and the output side.

Parameters:
- OP_WIDTH, 16, operand width in bits. Must be a multiple of 8 and at least 8. Chunk count C = OP_WIDTH/8. Pass count P = C*C.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair presented
- in_ready  out  1  controller can accept an operand pair
- a  in  OP_WIDTH  multiplicand, unsigned
- b  in  OP_WIDTH  multiplier, unsigned
- out_valid  out  1  product available
- out_ready  in  1  consumer accepts the product
- r  out  2*OP_WIDTH  product a*b, unsigned

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, in_ready=0 while reset is held, out_valid=0, r=0, accumulator=0, chunk counters i=j=0.
- In IDLE, in_ready=1 starting the first cycle after reset deasserts.
- Accept: on an edge where in_valid&&in_ready:
  - capture a and b into internal registers;
  - clear the accumulator and set i=j=0;
  - go to RUN; in_ready drops to 0.
- RUN, each cycle:
  - drive vedic_8x8 with a_reg[8i+:8] and b_reg[8j+:8];
  - add its 16-bit output, shifted left by 8*(i+j), into a 2*OP_WIDTH accumulator.
- Counter order: j increments first; on j==C-1, j wraps to 0 and i increments.
- Last pass is i==C-1 and j==C-1. After it, go to DONE, copy the accumulator into r and set out_valid=1.
- Latency: out_valid rises exactly P cycles after the accept edge (4 for the default 16-bit width).
- Accumulator arithmetic: carries propagate across the full 2*OP_WIDTH width. No overflow is possible because the final sum equals a*b.
- DONE:
  - r and out_valid hold stable while out_ready=0.
  - On out_valid&&out_ready: clear out_valid, go to IDLE, set in_ready=1 the next cycle.
  - r keeps its last value after the handshake.
- No input/output overlap: in_ready=0 throughout RUN and DONE. A new operand pair cannot be accepted in the same cycle the result is consumed.
- in_valid while busy is ignored and creates no queue. a and b may change freely after the accept edge.
- Reset mid-RUN or mid-DONE: all state and outputs return to reset values immediately and the partial result is discarded.
- States: IDLE, RUN, DONE. An illegal encoding recovers to IDLE.

Optional Feature:
- Macro: ITER_MULT_ZERO_SKIP_EN.
- When defined: if a==0 or b==0 at the accept edge, skip RUN, go directly to DONE with r=0, and raise out_valid 1 cycle after accept.
- When undefined: every accept takes the full P passes.
- All other timing is identical either way.

Decomposition:
- Shared package iter_mult_pkg holds:
  - enum mult_state_t {IDLE, RUN, DONE};
  - constant CHUNK_W=8;
  - function n_chunks(OP_WIDTH).
- Sub-module: exactly one vedic_8x8 instance (existing block) as the per-pass datapath. All sequencing, counters and the accumulator live in iter_mult_ctrl.

Test Plan:
- a=0x1234, b=0x5678, out_ready=1 -> out_valid exactly 4 cycles after the accept edge, r=0x06260060, in_ready=1 the cycle after the output handshake.
- a=0xFFFF, b=0xFFFF -> r=0xFFFE0001, confirming full carry propagation. a=0x0001, b=0xFFFF -> r=0x0000FFFF.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> r and out_valid stable, in_ready=0, and a second in_valid pulse in that window is ignored; out_ready=1 -> one handshake, then IDLE.
- Reset asserted 2 cycles into RUN -> out_valid=0, r=0, in_ready=0 while reset is held; after release, a fresh accept of 0x00FF*0x0100 gives r=0x0000FF00 after 4 cycles.
- a=0x0000, b=0xBEEF -> r=0. With ITER_MULT_ZERO_SKIP_EN, out_valid comes 1 cycle after accept; without it, 4 cycles.
- Randomised: 1e5 random 16-bit pairs with random out_ready stalls -> every r equals a*b and every accept produces exactly one output handshake.

Source files
------------

// File: rtl/iter_mult_pkg.sv
// Shared definitions for the iterative wide multiplier.
//   mult_state_t : controller states (IDLE, RUN, DONE)
//   CHUNK_W      : width of one operand chunk fed to vedic_8x8
//   n_chunks()   : number of chunks an operand of a given width splits into
package iter_mult_pkg;

  localparam int CHUNK_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  function automatic int n_chunks(input int op_width);
    return op_width / CHUNK_W;
  endfunction

endpackage

// File: rtl/vedic_8x8.sv
// Combinational 8x8 unsigned multiplier, Vedic (Urdhva-Tiryagbhyam) style:
// four 4x4 partial products combined with shifted additions.
//   i_a, i_b : 8-bit unsigned operands
//   o_p      : 16-bit unsigned product
module vedic_8x8 (
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_p
);

  logic [7:0] w_ll;
  logic [7:0] w_lh;
  logic [7:0] w_hl;
  logic [7:0] w_hh;

  assign w_ll = i_a[3:0] * i_b[3:0];
  assign w_lh = i_a[3:0] * i_b[7:4];
  assign w_hl = i_a[7:4] * i_b[3:0];
  assign w_hh = i_a[7:4] * i_b[7:4];

  assign o_p = 16'(w_ll) + (16'(w_lh) << 4) + (16'(w_hl) << 4) + (16'(w_hh) << 8);

endmodule

// File: rtl/iter_mult_ctrl.sv
// Multi-cycle unsigned multiplier controller. Splits a and b into 8-bit
// chunks and runs one chunk pair per cycle through a single vedic_8x8,
// shift-accumulating the partial products. C*C passes per product.
// Optional build macro: ITER_MULT_ZERO_SKIP_EN -- a zero operand at accept
// produces r=0 one cycle after accept instead of running all passes.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   in_valid  / in_ready  : operand handshake (a, b)
//   out_valid / out_ready : product handshake (r)
//   a, b      : OP_WIDTH-bit unsigned operands (OP_WIDTH multiple of 8, >= 8)
//   r         : 2*OP_WIDTH-bit product, held after the output handshake
module iter_mult_ctrl
  import iter_mult_pkg::*;
#(
  parameter int OP_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_WIDTH-1:0]     a,
  input  logic [OP_WIDTH-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*OP_WIDTH-1:0]   r
);

  localparam int C     = n_chunks(OP_WIDTH);
  localparam int CNT_W = (C > 1) ? $clog2(C) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(C - 1);

  mult_state_t r_state;
  mult_state_t w_state_nxt;

  logic [OP_WIDTH-1:0]   r_a;
  logic [OP_WIDTH-1:0]   r_b;
  logic [2*OP_WIDTH-1:0] r_acc;
  logic [2*OP_WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]      r_i;
  logic [CNT_W-1:0]      r_j;
  logic                  r_in_ready;
  logic                  r_out_valid;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_out_fire;
  logic                  w_zero_skip;
  logic [OP_WIDTH-1:0]   w_a_sh;
  logic [OP_WIDTH-1:0]   w_b_sh;
  logic [7:0]            w_a_chunk;
  logic [7:0]            w_b_chunk;
  logic [15:0]           w_pp;
  logic [2*OP_WIDTH-1:0] w_pp_sh;
  logic [2*OP_WIDTH-1:0] w_acc_sum;

`ifdef ITER_MULT_ZERO_SKIP_EN
  assign w_zero_skip = (a == '0) || (b == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  // Chunk selection by shifting keeps the index arithmetic width-clean.
  assign w_a_sh    = r_a >> (CHUNK_W * int'(r_i));
  assign w_b_sh    = r_b >> (CHUNK_W * int'(r_j));
  assign w_a_chunk = w_a_sh[CHUNK_W-1:0];
  assign w_b_chunk = w_b_sh[CHUNK_W-1:0];

  vedic_8x8 u_vedic (
    .i_a (w_a_chunk),
    .i_b (w_b_chunk),
    .o_p (w_pp)
  );

  assign w_pp_sh   = (2*OP_WIDTH)'(w_pp) << (CHUNK_W * (int'(r_i) + int'(r_j)));
  assign w_acc_sum = r_acc + w_pp_sh;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_out_fire  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if ((r_i == LAST) && (r_j == LAST)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (r_out_valid && out_ready) begin
          w_out_fire  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_prod      <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Registered so in_ready stays low while reset is held and rises
      // one cycle after returning to IDLE.
      r_in_ready <= (w_state_nxt == IDLE);

      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_acc <= '0;
        // Zero skip: a single pass on the last chunk pair yields zero and
        // reaches DONE on the next edge.
        r_i   <= w_zero_skip ? LAST : '0;
        r_j   <= w_zero_skip ? LAST : '0;
      end else if (r_state == RUN) begin
        r_acc <= w_acc_sum;
        if (r_j == LAST) begin
          r_j <= '0;
          r_i <= (r_i == LAST) ? '0 : r_i + 1'b1;
        end else begin
          r_j <= r_j + 1'b1;
        end
      end

      if (w_last) begin
        r_prod      <= w_acc_sum;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign r         = r_prod;

endmodule
